// File: rtl/frogger_pkg.sv
// Shared game types and widths, used by the sequencer, the HUD and the renderer.
package frogger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DEATH     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  localparam int NUM_HOMES = 5;
  localparam int LIVES_W   = 2;
  localparam int LEVEL_W   = 4;
  localparam int SCORE_W   = 16;
  localparam int HOLDOFF_W = 26;

  // Clamp a one-bit-wider sum back into the score range instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W:0] s);
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/game_state_ctrl_holdoff_timer.sv
// Reloadable down-counter pause. load starts a CYCLES-long pause; done is high
// whenever the counter has run out (also when idle).
module holdoff_timer
  import frogger_pkg::*;
#(
  parameter int CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic Reset,
  input  logic load,
  output logic done
);

  localparam logic [HOLDOFF_W-1:0] LOAD_VAL = HOLDOFF_W'(CYCLES - 1);

  logic [HOLDOFF_W-1:0] cnt;

  // Load takes priority; otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)          cnt <= '0;
    else if (load)       cnt <= LOAD_VAL;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/game_state_ctrl.sv
// Frogger game sequencer: lives, level, score and home-slot occupancy, and the
// start/end/level handshake toward the countdown timer.
module game_state_ctrl
  import frogger_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int MAX_LEVEL      = 9,
  parameter int HOLDOFF_CYCLES = 50_000_000,
  parameter int SCORE_HOME     = 50,
  parameter int SCORE_PER_SEC  = 10,
  parameter int SCORE_LEVEL    = 1000
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 start_key,
  input  logic                 frog_died,
  input  logic                 frog_home,
  input  logic [2:0]           home_idx,
  input  logic [5:0]           tim,
  output logic                 gameStart,
  output logic                 gameEnd,
  output logic [LEVEL_W-1:0]   level,
  output logic [LIVES_W-1:0]   lives,
  output logic [SCORE_W-1:0]   score,
  output logic [NUM_HOMES-1:0] homes,
  output logic                 respawn
);

  localparam int SUM_W = SCORE_W + 1;

  game_state_t          state_q, state_d;
  logic [LIVES_W-1:0]   lives_d;
  logic [LEVEL_W-1:0]   level_d;
  logic [SCORE_W-1:0]   score_d;
  logic [NUM_HOMES-1:0] homes_d;
  logic                 hold_load, hold_done;
  logic                 gs_d, ge_d, rsp_d;

  logic [NUM_HOMES-1:0] hit;
  logic                 slot_bad, mask_full;
  logic [SUM_W-1:0]     home_sum;

  holdoff_timer #(.CYCLES(HOLDOFF_CYCLES)) u_hold (
    .clk   (clk),
    .Reset (Reset),
    .load  (hold_load),
    .done  (hold_done)
  );

  // An out-of-range index shifts the one-hot off the end, so it looks occupied.
  assign hit       = {{(NUM_HOMES-1){1'b0}}, 1'b1} << home_idx;
  assign slot_bad  = (hit == '0) || ((homes_q_any(homes, hit)));
  assign mask_full = &(homes | hit);
  assign home_sum  = SUM_W'(score) + SUM_W'(SCORE_HOME) + SUM_W'(tim) * SUM_W'(SCORE_PER_SEC)
                   + (mask_full ? SUM_W'(SCORE_LEVEL) : SUM_W'(0));

  function automatic logic homes_q_any(input logic [NUM_HOMES-1:0] m, input logic [NUM_HOMES-1:0] h);
    return |(m & h);
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      lives   <= LIVES_W'(LIVES_INIT);
      level   <= LEVEL_W'(1);
      score   <= '0;
      homes   <= '0;
    end else begin
      state_q <= state_d;
      lives   <= lives_d;
      level   <= level_d;
      score   <= score_d;
      homes   <= homes_d;
    end
  end

  // Next state plus lives/level/score/homes updates; death outranks homing.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives;
    level_d   = level;
    score_d   = score;
    homes_d   = homes;
    hold_load = 1'b0;
    case (state_q)
      ST_IDLE: if (start_key) state_d = ST_PLAY;
      ST_PLAY: begin
        if (frog_died || (tim == '0) || (frog_home && slot_bad)) begin
          if (lives == LIVES_W'(1)) begin
            lives_d = '0;
            state_d = ST_GAME_OVER;
          end else begin
            lives_d   = lives - 1'b1;
            state_d   = ST_DEATH;
            hold_load = 1'b1;
          end
        end else if (frog_home) begin
          score_d = sat_score(home_sum);
          homes_d = homes | hit;
          if (mask_full) begin
            homes_d   = '0;
            level_d   = (level == LEVEL_W'(MAX_LEVEL)) ? level : level + 1'b1;
            state_d   = ST_LEVEL_UP;
            hold_load = 1'b1;
          end
        end
      end
      ST_DEATH, ST_LEVEL_UP: if (hold_done) state_d = ST_PLAY;
      ST_GAME_OVER: if (start_key) begin
        state_d = ST_PLAY;
        lives_d = LIVES_W'(LIVES_INIT);
        level_d = LEVEL_W'(1);
        score_d = '0;
        homes_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    gs_d  = (state_d == ST_PLAY);
    ge_d  = (state_d == ST_GAME_OVER);
    rsp_d = (state_d == ST_PLAY) && (state_q != ST_PLAY);
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      gameStart <= 1'b0;
      gameEnd   <= 1'b0;
      respawn   <= 1'b0;
    end else begin
      gameStart <= gs_d;
      gameEnd   <= ge_d;
      respawn   <= rsp_d;
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with a 4-cycle holdoff.
module tb_game_state_ctrl;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start_key = 1'b0, frog_died = 1'b0, frog_home = 1'b0;
  logic [2:0]  home_idx = 3'd0;
  logic [5:0]  tim = 6'd40;
  logic        gameStart, gameEnd, respawn;
  logic [3:0]  level;
  logic [1:0]  lives;
  logic [15:0] score;
  logic [4:0]  homes;

  int total = 0;
  int bad   = 0;

  game_state_ctrl #(.HOLDOFF_CYCLES(4)) dut (
    .clk(clk), .Reset(Reset), .start_key(start_key), .frog_died(frog_died),
    .frog_home(frog_home), .home_idx(home_idx), .tim(tim),
    .gameStart(gameStart), .gameEnd(gameEnd), .level(level), .lives(lives),
    .score(score), .homes(homes), .respawn(respawn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sk, fd, fh; logic [2:0] idx; logic [5:0] t;
    logic gs, ge, rsp; logic [3:0] lvl; logic [1:0] lv; logic [15:0] sc; logic [4:0] hm;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic sk, fd, fh, input logic [2:0] idx, input logic [5:0] t,
                              input logic gs, ge, rsp, input logic [3:0] lvl, input logic [1:0] lv,
                              input logic [15:0] sc, input logic [4:0] hm);
    vec_t v;
    v.sk = sk; v.fd = fd; v.fh = fh; v.idx = idx; v.t = t;
    v.gs = gs; v.ge = ge; v.rsp = rsp; v.lvl = lvl; v.lv = lv; v.sc = sc; v.hm = hm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One clock: drive inputs, let the edge take them, sample 1 time unit later.
  task automatic cyc(input logic sk, fd, fh, input logic [2:0] idx, input logic [5:0] t);
    start_key = sk; frog_died = fd; frog_home = fh; home_idx = idx; tim = t;
    @(posedge clk); #1;
    start_key = 1'b0; frog_died = 1'b0; frog_home = 1'b0;
  endtask

  task automatic chk_all(input string name, input logic gs, ge, rsp, input logic [3:0] lvl,
                         input logic [1:0] lv, input logic [15:0] sc, input logic [4:0] hm);
    chk({name, ".gameStart"}, 32'(gameStart), 32'(gs));
    chk({name, ".gameEnd"},   32'(gameEnd),   32'(ge));
    chk({name, ".respawn"},   32'(respawn),   32'(rsp));
    chk({name, ".level"},     32'(level),     32'(lvl));
    chk({name, ".lives"},     32'(lives),     32'(lv));
    chk({name, ".score"},     32'(score),     32'(sc));
    chk({name, ".homes"},     32'(homes),     32'(hm));
  endtask

  initial begin
    int exp_sc, exp_lvl, inc, n;
    logic [5:0] t;

    // sk fd fh idx t | gs ge rsp lvl lv score homes
    tbl[0]  = mk(1'b0,1'b0,1'b0,3'd0,6'd40, 1'b0,1'b0,1'b0,4'd1,2'd3,16'd0,  5'b00000); // idle
    tbl[1]  = mk(1'b1,1'b0,1'b0,3'd0,6'd40, 1'b1,1'b0,1'b1,4'd1,2'd3,16'd0,  5'b00000); // start
    tbl[2]  = mk(1'b0,1'b0,1'b0,3'd0,6'd40, 1'b1,1'b0,1'b0,4'd1,2'd3,16'd0,  5'b00000);
    tbl[3]  = mk(1'b0,1'b0,1'b1,3'd2,6'd40, 1'b1,1'b0,1'b0,4'd1,2'd3,16'd450,5'b00100); // home 2
    tbl[4]  = mk(1'b1,1'b0,1'b0,3'd0,6'd40, 1'b1,1'b0,1'b0,4'd1,2'd3,16'd450,5'b00100); // start ignored
    tbl[5]  = mk(1'b0,1'b1,1'b1,3'd3,6'd40, 1'b0,1'b0,1'b0,4'd1,2'd2,16'd450,5'b00100); // death wins
    tbl[6]  = mk(1'b0,1'b0,1'b1,3'd0,6'd40, 1'b0,1'b0,1'b0,4'd1,2'd2,16'd450,5'b00100); // home ignored
    tbl[7]  = mk(1'b0,1'b0,1'b0,3'd0,6'd40, 1'b0,1'b0,1'b0,4'd1,2'd2,16'd450,5'b00100);
    tbl[8]  = mk(1'b0,1'b0,1'b0,3'd0,6'd40, 1'b0,1'b0,1'b0,4'd1,2'd2,16'd450,5'b00100);
    tbl[9]  = mk(1'b0,1'b0,1'b0,3'd0,6'd40, 1'b1,1'b0,1'b1,4'd1,2'd2,16'd450,5'b00100); // respawn
    tbl[10] = mk(1'b0,1'b0,1'b0,3'd0,6'd40, 1'b1,1'b0,1'b0,4'd1,2'd2,16'd450,5'b00100);
    tbl[11] = mk(1'b0,1'b0,1'b1,3'd2,6'd40, 1'b0,1'b0,1'b0,4'd1,2'd1,16'd450,5'b00100); // filled slot
    tbl[12] = mk(1'b0,1'b0,1'b0,3'd0,6'd40, 1'b0,1'b0,1'b0,4'd1,2'd1,16'd450,5'b00100);
    tbl[13] = mk(1'b0,1'b0,1'b0,3'd0,6'd40, 1'b0,1'b0,1'b0,4'd1,2'd1,16'd450,5'b00100);
    tbl[14] = mk(1'b0,1'b0,1'b0,3'd0,6'd40, 1'b0,1'b0,1'b0,4'd1,2'd1,16'd450,5'b00100);
    tbl[15] = mk(1'b0,1'b0,1'b0,3'd0,6'd40, 1'b1,1'b0,1'b1,4'd1,2'd1,16'd450,5'b00100);
    tbl[16] = mk(1'b0,1'b0,1'b1,3'd7,6'd40, 1'b0,1'b1,1'b0,4'd1,2'd0,16'd450,5'b00100); // bad idx, last life
    tbl[17] = mk(1'b1,1'b1,1'b0,3'd0,6'd40, 1'b1,1'b0,1'b1,4'd1,2'd3,16'd0,  5'b00000); // restart

    #3 Reset = 1'b0;
    #1 chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd1, 2'd3, 16'd0, 5'b00000);
    @(posedge clk); #1 Reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].sk, tbl[i].fd, tbl[i].fh, tbl[i].idx, tbl[i].t);
      chk_all($sformatf("vec%0d", i), tbl[i].gs, tbl[i].ge, tbl[i].rsp, tbl[i].lvl,
              tbl[i].lv, tbl[i].sc, tbl[i].hm);
    end

    // Level-ups: first at tim=16 (score 2050), then tim=63 until score clamps and level holds at 9.
    exp_sc = 0; exp_lvl = 1;
    for (int l = 0; l < 17; l++) begin
      t = (l == 0) ? 6'd16 : 6'd63;
      for (int s = 0; s < 5; s++) begin
        inc = 50 + int'(t) * 10 + ((s == 4) ? 1000 : 0);
        exp_sc = (exp_sc + inc > 65535) ? 65535 : exp_sc + inc;
        cyc(1'b0, 1'b0, 1'b1, 3'(s), t);
        chk("lvl_score", 32'(score), 32'(exp_sc));
      end
      exp_lvl = (exp_lvl == 9) ? 9 : exp_lvl + 1;
      if (l == 0) chk("first_level_score", 32'(score), 32'd2050);
      chk("lvl_level", 32'(level), 32'(exp_lvl));
      chk("lvl_homes", 32'(homes), 32'd0);
      chk("lvl_gs0", 32'(gameStart), 32'd0);
      for (int k = 0; k < 3; k++) begin
        cyc(1'b0, 1'b0, 1'b0, 3'd0, t);
        chk("lvl_hold_gs", 32'(gameStart), 32'd0);
        chk("lvl_hold_rsp", 32'(respawn), 32'd0);
      end
      cyc(1'b0, 1'b0, 1'b0, 3'd0, t);
      chk("lvl_exit_gs", 32'(gameStart), 32'd1);
      chk("lvl_exit_rsp", 32'(respawn), 32'd1);
    end
    chk("score_clamped", 32'(score), 32'hFFFF);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 6'd63);
    chk("score_stays_clamped", 32'(score), 32'hFFFF);

    // Timeout deaths: tim held at 0 burns all three lives.
    n = 0;
    while (!gameEnd && n < 40) begin
      cyc(1'b0, 1'b0, 1'b0, 3'd0, 6'd0);
      n++;
    end
    chk("tim0_cycles", 32'(n), 32'd11);
    chk("tim0_gameEnd", 32'(gameEnd), 32'd1);
    chk("tim0_lives", 32'(lives), 32'd0);
    chk("tim0_gameStart", 32'(gameStart), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 6'd40);
    chk_all("restart", 1'b1, 1'b0, 1'b1, 4'd1, 2'd3, 16'd0, 5'b00000);

    // Async reset mid-PLAY wipes progress without a respawn pulse.
    cyc(1'b0, 1'b0, 1'b1, 3'd1, 6'd40);
    chk("pre_reset_score", 32'(score), 32'd450);
    #2 Reset = 1'b0;
    #1 chk_all("mid_reset", 1'b0, 1'b0, 1'b0, 4'd1, 2'd3, 16'd0, 5'b00000);
    @(posedge clk); #1;
    chk_all("mid_reset_hold", 1'b0, 1'b0, 1'b0, 4'd1, 2'd3, 16'd0, 5'b00000);
    Reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
